// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter : iterative 32-bit radix-2 restoring divider (DIV / DIVU)
//
// Multi-cycle partner of the execute-stage ALU. A request is accepted in IDLE,
// one quotient bit is produced per BUSY cycle, and the {remainder, quotient}
// pair is presented for one cycle in DONE for the HI/LO write.
//
// Handshake: div_start is a request that is only looked at in IDLE. The
// divider holds div_stall high from the accepting cycle through every BUSY
// cycle. div_ready is a single-cycle valid pulse with no back-pressure; the
// pipeline consumes div_result in that cycle. div_result stays stable until
// the next completion. div_cancel drops any operation in progress and wins
// over a simultaneous div_start.
//
// Optional build macro: DIV_ZERO_FASTPATH_EN
//   defined   : a zero divisor seen in IDLE goes straight to DONE (latency 2)
//   undefined : a zero divisor runs all iterations, then forces the result
//
// Ports
//   clk          in   core clock, rising edge
//   rst          in   asynchronous active-high reset
//   div_start    in   start request (IDLE only)
//   div_signed   in   1 = DIV (two's complement), 0 = DIVU
//   div_src1     in   dividend [WIDTH-1:0]
//   div_src2     in   divisor  [WIDTH-1:0]
//   div_cancel   in   flush / exception abort
//   div_stall    out  pipeline stall request
//   div_ready    out  one-cycle result-valid pulse
//   div_result   out  {remainder, quotient} [2*WIDTH-1:0]
//   o_dbg_state  out  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// ---------------------------------------------------------------------------
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic [WIDTH-1:0]   div_src1,
  input  logic [WIDTH-1:0]   div_src2,
  input  logic               div_cancel,
  output logic               div_stall,
  output logic               div_ready,
  output logic [2*WIDTH-1:0] div_result,
  output logic [1:0]         o_dbg_state
);

  localparam int CW = $clog2(WIDTH);

`ifdef DIV_ZERO_FASTPATH_EN
  localparam bit FASTPATH = 1'b1;
`else
  localparam bit FASTPATH = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0]      r_count;
  logic               r_signed;
  logic               r_s1_neg;
  logic               r_s2_neg;
  logic [WIDTH-1:0]   r_src1;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [2*WIDTH-1:0] r_result;

  logic               w_accept;
  logic               w_src1_neg;
  logic               w_src2_neg;
  logic [WIDTH-1:0]   w_src1_mag;
  logic [WIDTH-1:0]   w_src2_mag;
  logic               w_src2_zero;
  logic               w_fast_zero;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic               w_trial_ok;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [2*WIDTH-1:0] w_final;
  logic               w_last;
  logic               w_load_result;

  // -------------------------------------------------------------------------
  // Operand conditioning for the accepting cycle
  // -------------------------------------------------------------------------
  assign w_accept    = (r_state == S_IDLE) && div_start && !div_cancel;
  assign w_src1_neg  = div_signed && div_src1[WIDTH-1];
  assign w_src2_neg  = div_signed && div_src2[WIDTH-1];
  assign w_src1_mag  = w_src1_neg ? (~div_src1 + 1'b1) : div_src1;
  assign w_src2_mag  = w_src2_neg ? (~div_src2 + 1'b1) : div_src2;
  assign w_src2_zero = (div_src2 == '0);
  assign w_fast_zero = FASTPATH && w_src2_zero;

  // -------------------------------------------------------------------------
  // One restoring step. The partial remainder is always below the divisor,
  // so after the shift it fits in WIDTH+1 bits and bit WIDTH of the
  // (WIDTH+1)-bit difference is a reliable borrow / negative flag.
  // -------------------------------------------------------------------------
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_dvs};
  assign w_trial_ok = !w_trial[WIDTH];
  assign w_rem_next = w_trial_ok ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_trial_ok};
  assign w_last     = (r_count == CW'(WIDTH - 1));

  // Sign fix-up: quotient negative when signs differ, remainder follows the
  // dividend. r_s*_neg are already qualified by signed mode. The most
  // negative dividend over -1 wraps back to itself, which is the
  // architected overflow answer.
  assign w_quo_fix = (r_s1_neg ^ r_s2_neg) ? (~w_quo_next + 1'b1) : w_quo_next;
  assign w_rem_fix = r_s1_neg ? (~w_rem_next + 1'b1) : w_rem_next;

  // Divide by zero returns the untouched dividend as remainder.
  assign w_final = (r_dvs == '0) ? {r_src1, {WIDTH{1'b1}}}
                                 : {w_rem_fix, w_quo_fix};

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_load_result = 1'b0;
    div_stall     = 1'b0;
    div_ready     = 1'b0;

    case (r_state)
      S_IDLE: begin
        div_stall = div_start && !div_cancel && !rst;
        if (w_accept) begin
          if (w_fast_zero) begin
            w_state_next  = S_DONE;
            w_load_result = 1'b1;
          end else begin
            w_state_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        div_stall = 1'b1;
        if (w_last) begin
          w_state_next  = S_DONE;
          w_load_result = !div_cancel;
        end
      end
      S_DONE: begin
        div_ready    = !div_cancel;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (div_cancel) begin
      w_state_next = S_IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_signed <= 1'b0;
      r_s1_neg <= 1'b0;
      r_s2_neg <= 1'b0;
      r_src1   <= '0;
      r_dvs    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_result <= '0;
    end else begin
      if (div_cancel) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_count  <= '0;
        r_signed <= div_signed;
        r_s1_neg <= w_src1_neg;
        r_s2_neg <= w_src2_neg;
        r_src1   <= div_src1;
        r_dvs    <= w_src2_mag;
        r_quo    <= w_src1_mag;
        r_rem    <= '0;
      end else if (r_state == S_BUSY) begin
        // Wraps to zero after the final step, leaving the counter cleared.
        r_count <= r_count + 1'b1;
        r_quo   <= w_quo_next;
        r_rem   <= w_rem_next;
      end

      if (w_load_result) begin
        // Fast path result is built directly from the live request.
        if (r_state == S_IDLE) begin
          r_result <= {div_src1, {WIDTH{1'b1}}};
        end else begin
          r_result <= w_final;
        end
      end
    end
  end

  assign div_result  = r_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_cancel;
  logic        div_stall;
  logic        div_ready;
  logic [63:0] div_result;
  logic [1:0]  dbg_state;

  div_iter #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .div_start   (div_start),
    .div_signed  (div_signed),
    .div_src1    (div_src1),
    .div_src2    (div_src2),
    .div_cancel  (div_cancel),
    .div_stall   (div_stall),
    .div_ready   (div_ready),
    .div_result  (div_result),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef DIV_ZERO_FASTPATH_EN
  localparam int ZERO_LAT = 2;
`else
  localparam int ZERO_LAT = 34;
`endif

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          req_q[$];
  int          lat_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_ready  = 0;
  int          stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  // monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (div_stall) stall_cnt++;
      if (div_ready) begin
        logic [63:0] e;
        int r;
        int l;
        n_ready++;
        if (exp_q.size() == 0) begin
          check("unexpected_ready", div_result, 64'hx);
        end else begin
          e = exp_q.pop_front();
          r = req_q.pop_front();
          l = lat_q.pop_front();
          check("result", div_result, e);
          check("latency", 64'(cyc - r + 1), 64'(l));
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    div_signed = sgn;
    div_src1   = a;
    div_src2   = b;
    div_start  = 1'b1;
  endtask

  task automatic wait_ready(input int nb);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (n_ready != nb) break;
    end
    if (n_ready == nb) check("timeout", 64'(n_ready), 64'(nb + 1));
  endtask

  task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat);
    int nb;
    nb = n_ready;
    issue(sgn, a, b);
    exp_q.push_back(exp);
    req_q.push_back(cyc);
    lat_q.push_back(lat);
    @(posedge clk); #1;
    div_start = 1'b0;
    wait_ready(nb);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb;
    rst        = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_src1   = '0;
    div_src2   = '0;
    div_cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  64'(div_ready), 64'd0);
    check("rst_stall",  64'(div_stall), 64'd0);
    check("rst_result", div_result,     64'd0);
    check("rst_state",  64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic unsigned, with stall length
    stall_cnt = 0;
    do_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
    check("stall_cycles", 64'(stall_cnt), 64'd33);

    // signed cases and boundaries
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    do_op(1'b1, 32'd7,         32'hFFFF_FFFE,  {32'd1,         32'hFFFF_FFFD}, 34);
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7,          {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 34);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  {32'd0,         32'h8000_0000}, 34);
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF,  {32'h8000_0000, 32'd0},         34);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1,          {32'd0,         32'hFFFF_FFFF}, 34);

    // divide by zero (unsigned and signed, dividend returned unchanged)
    do_op(1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, ZERO_LAT);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, ZERO_LAT);

    // cancel on BUSY cycle 10: no ready, result kept, then 9/3
    issue(1'b0, 32'd100, 32'd7);
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    div_cancel = 1'b1;
    @(posedge clk); #1;
    div_cancel = 1'b0;
    check("cancel_idle", 64'(dbg_state), 64'd0);
    check("cancel_keep", div_result, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    do_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34);

    // start held high: no re-latch, one pulse, then a fresh op from IDLE
    nb = n_ready;
    issue(1'b0, 32'd100, 32'd7);
    exp_q.push_back({32'd2, 32'd14});
    req_q.push_back(cyc);
    lat_q.push_back(34);
    @(posedge clk); #1;
    div_src1 = 32'd9;
    div_src2 = 32'd3;
    wait_ready(nb);
    exp_q.push_back({32'd0, 32'd3});
    req_q.push_back(cyc);
    lat_q.push_back(34);
    nb = n_ready;
    @(posedge clk); #1;
    div_start = 1'b0;
    wait_ready(nb);

    // asynchronous reset mid-BUSY
    issue(1'b1, 32'hFFFF_FF9C, 32'd7);
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_ready",  64'(div_ready), 64'd0);
    check("arst_stall",  64'(div_stall), 64'd0);
    check("arst_result", div_result,     64'd0);
    check("arst_state",  64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
